bk_sram_arbiter: RTL and testbench
==================================

Name: bk_sram_arbiter

Overview:
- Sits directly downstream of the BK-0010 top-level RAM exchange cycle and drives the external asynchronous 16-bit SRAM.
- Arbitrates between two requesters:
  - CPU word/byte reads and writes.
  - Video shifter fetches, one word per 16 pixels.
- Provides cpu_rdata, a registered video word (vdata) and the membusy signal that the CPU clock-enable logic consumes.
- Video fetches have fixed priority; CPU accesses never corrupt an in-flight video read.

Parameters:
- ACCESS_CYC, 3, clk_cpu cycles SRAM address/OE/WE held per access (minimum 2).
- VID_BASE, 5'b00001, upper 5 bits of the 18-bit word address for video fetches (screen at octal 040000).
- WR_RECOVER, 1, idle cycles inserted after every write before the next access.

Ports:
- clk_cpu  in  1  system clock.
- reset_in  in  1  asynchronous, active-high reset.
- cpu_oe_n  in  1  CPU read request, active low, level held until cpu_ack.
- cpu_we_n  in  1  CPU write request, active low, level held until cpu_ack.
- cpu_addr  in  18  CPU word address.
- cpu_lb  in  1  CPU low-byte disable (1 = byte masked).
- cpu_ub  in  1  CPU high-byte disable (1 = byte masked).
- cpu_wdata  in  16  CPU write data.
- cpu_rdata  out  16  registered CPU read data.
- cpu_ack  out  1  one-cycle pulse: access complete.
- vid_req  in  1  one-cycle strobe: fetch video word.
- vid_addr  in  13  video word offset.
- vdata  out  16  registered video word.
- vid_valid  out  1  one-cycle pulse when vdata updates.
- membusy  out  1  video fetch pending or in progress.
- sram_addr  out  18  SRAM address.
- sram_dq_i  in  16  SRAM read data.
- sram_dq_o  out  16  SRAM write data.
- sram_dq_oe  out  1  1 = drive sram_dq_o.
- sram_oe_n  out  1  SRAM output enable.
- sram_we_n  out  1  SRAM write enable.
- sram_lb_n  out  1  SRAM low-byte enable.
- sram_ub_n  out  1  SRAM high-byte enable.
- stall_cnt  out  16  CPU stall counter (see Optional Feature).

Behaviour:
- Reset values:
  - All sram_*_n outputs = 1; sram_dq_oe = 0.
  - cpu_ack, vid_valid, membusy = 0.
  - cpu_rdata, vdata, stall_cnt = 0.
  - State = IDLE; vid_pend = 0.
- vid_req handling:
  - A vid_req strobe sets the vid_pend flag and latches vid_addr.
  - A vid_req arriving while vid_pend = 1 overwrites the latched address; only one fetch is performed.
- membusy = vid_pend | (state == VID), registered; it goes high the cycle after vid_req.
- IDLE arbitration, fixed priority:
  - vid_pend → VID.
  - else ~cpu_we_n → CPU_WR.
  - else ~cpu_oe_n → CPU_RD.
  - cpu_oe_n and cpu_we_n both low is illegal; the write wins.
- VID:
  - sram_addr = {VID_BASE, latched vid_addr}; sram_oe_n = 0; both byte enables = 0.
  - Held ACCESS_CYC cycles; on the last cycle vdata <= sram_dq_i and vid_valid pulses.
  - vid_pend clears on entry to VID.
  - Return to IDLE.
- CPU_RD:
  - sram_addr = cpu_addr; sram_lb_n = cpu_lb; sram_ub_n = cpu_ub; sram_oe_n = 0.
  - Held ACCESS_CYC cycles; on the last cycle cpu_rdata <= sram_dq_i and cpu_ack pulses.
  - Return to IDLE.
- CPU_WR:
  - sram_dq_oe = 1 and data stable for the whole access.
  - sram_we_n = 0 from cycle 2 to cycle ACCESS_CYC−1 only, so address setup and hold are one cycle each.
  - cpu_ack pulses on the last cycle, then REC for WR_RECOVER cycles, then IDLE.
- Latency with no contention: CPU read data on cycle 1+ACCESS_CYC after the request is seen in IDLE.
- Worst-case CPU latency = 2·ACCESS_CYC + WR_RECOVER + 2 cycles.
- The requester must not drop its request before cpu_ack. If a request drops mid-access anyway, the access completes and cpu_ack still pulses.
- A vid_req during a CPU access is queued and served immediately after that access (plus REC if it was a write).
- The access counter is 3 bits and never wraps past ACCESS_CYC−1.
- Asynchronous reset mid-access immediately releases all SRAM strobes (the _n outputs go to 1) and clears vid_pend.

Optional Feature:
- Macro BKMEM_STALL_STATS_EN.
- Defined:
  - stall_cnt increments each cycle a CPU request is pending in IDLE or VID while the block is not serving it.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: stall_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Package bk_mem_pkg holds:
  - State encoding: IDLE, VID, CPU_RD, CPU_WR, REC (3-bit).
  - VID_BASE default.
  - Localparam CNT_W = 3.
- Sub-module bk_sram_timer: loadable down-counter producing last/we_window flags, reused for ACCESS_CYC and WR_RECOVER.

Test Plan:
- Read:
  - Stimulus: preload SRAM[0x00100] = 16'hA5C3; hold cpu_oe_n = 0, cpu_addr = 0x00100.
  - Response: cpu_ack after 4 cycles, cpu_rdata = 16'hA5C3; sram_oe_n low exactly 3 cycles.
- Byte write:
  - Stimulus: cpu_we_n = 0, cpu_addr = 0x00200, cpu_ub = 1, cpu_lb = 0, cpu_wdata = 16'h1234 over SRAM 16'hFFFF.
  - Response: SRAM = 16'hFF34; sram_we_n low 1 cycle; one REC cycle before the next access.
- Contention:
  - Stimulus: vid_req with vid_addr = 13'h0005 on the same cycle cpu_oe_n falls.
  - Response: sram_addr = 18'h02005 first, vid_valid, then the CPU access; membusy high until VID exits.
- Queued video:
  - Stimulus: vid_req mid-CPU_WR.
  - Response: VID starts after REC; the write completes unmodified.
- Reset:
  - Stimulus: reset_in asserted during CPU_RD cycle 2.
  - Response: sram_oe_n = 1 immediately; cpu_ack never pulses; IDLE after release.
- Stats (BKMEM_STALL_STATS_EN defined):
  - Stimulus: CPU read blocked by one video fetch.
  - Response: stall_cnt = 3.

Source files
------------

// File: rtl/bk_mem_pkg.sv
// Shared constants for the BK-0010 SRAM arbiter: state encoding, counter width,
// default video base and the timer load helper.
package bk_mem_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VID    = 3'd1;
  localparam logic [2:0] CPU_RD = 3'd2;
  localparam logic [2:0] CPU_WR = 3'd3;
  localparam logic [2:0] REC    = 3'd4;

  // Screen buffer lives at octal 040000 (word address 18'h02000).
  localparam logic [4:0] VID_BASE_DEF = 5'b00001;

  // A phase of N cycles loads N-1 so the timer reads zero on its final cycle.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    int unsigned n;
    n = (cycles == 0) ? 0 : cycles - 1;
    return CNT_W'(n);
  endfunction

endpackage

// File: rtl/bk_sram_arbiter_if.sv
// Bus bundle between the RAM exchange cycle / video shifter and the SRAM arbiter,
// including the external SRAM pins. The arbiter uses the slave view.
interface bk_sram_arbiter_if;
  logic        cpu_oe_n;
  logic        cpu_we_n;
  logic [17:0] cpu_addr;
  logic        cpu_lb;
  logic        cpu_ub;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [15:0] vdata;
  logic        vid_valid;
  logic        membusy;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_lb_n;
  logic        sram_ub_n;
  logic [15:0] stall_cnt;

  modport slave (
    input  cpu_oe_n, cpu_we_n, cpu_addr, cpu_lb, cpu_ub, cpu_wdata,
    input  vid_req, vid_addr, sram_dq_i,
    output cpu_rdata, cpu_ack, vdata, vid_valid, membusy,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n,
    output sram_lb_n, sram_ub_n, stall_cnt
  );

  modport master (
    output cpu_oe_n, cpu_we_n, cpu_addr, cpu_lb, cpu_ub, cpu_wdata,
    output vid_req, vid_addr, sram_dq_i,
    input  cpu_rdata, cpu_ack, vdata, vid_valid, membusy,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n,
    input  sram_lb_n, sram_ub_n, stall_cnt
  );
endinterface

// File: rtl/bk_sram_timer.sv
// Loadable saturating down-counter timing one SRAM access or recovery phase.
// o_last marks the final cycle; o_we_window excludes the first and last cycles.
module bk_sram_timer
  import bk_mem_pkg::*;
#(
  parameter int unsigned WIN_TOP = 2
) (
  input  logic             clk_cpu,
  input  logic             reset_in,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_last,
  output logic             o_we_window
);

  localparam logic [CNT_W-1:0] TOP = CNT_W'(WIN_TOP);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last      = (r_cnt == '0);
  assign o_we_window = (r_cnt != '0) && (r_cnt < TOP);

endmodule

// File: rtl/bk_sram_arbiter.sv
// BK-0010 external SRAM arbiter: fixed-priority video fetch over CPU read/write.
// Optional CPU stall statistics are built when BKMEM_STALL_STATS_EN is defined.
module bk_sram_arbiter
  import bk_mem_pkg::*;
#(
  parameter int unsigned ACCESS_CYC = 3,
  parameter logic [4:0]  VID_BASE   = VID_BASE_DEF,
  parameter int unsigned WR_RECOVER = 1
) (
  input  logic             clk_cpu,
  input  logic             reset_in,
  bk_sram_arbiter_if.slave bus
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_vid_pend;
  logic             w_vid_pend_nxt;
  logic [12:0]      r_vid_addr;
  logic [17:0]      r_acc_addr;
  logic             r_acc_lb;
  logic             r_acc_ub;
  logic [15:0]      r_acc_wdata;
  logic [15:0]      r_cpu_rdata;
  logic [15:0]      r_vdata;
  logic             r_cpu_ack;
  logic             r_vid_valid;
  logic             r_membusy;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_last;
  logic             w_we_window;
  logic             w_cpu_req;
  logic             w_grant_vid;
  logic             w_grant_cpu;
  logic             w_in_acc;

  // The requester sees cpu_ack one cycle late, so its still-held request is ignored then.
  assign w_cpu_req = (~bus.cpu_oe_n | ~bus.cpu_we_n) & ~r_cpu_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = cnt_load(ACCESS_CYC);
    w_grant_vid = 1'b0;
    w_grant_cpu = 1'b0;
    case (r_state)
      IDLE: begin
        // A strobe arriving this very cycle already counts as pending.
        if (bus.vid_req || r_vid_pend) begin
          w_state_nxt = VID;
          w_load      = 1'b1;
          w_grant_vid = 1'b1;
        end else if (w_cpu_req && !bus.cpu_we_n) begin
          w_state_nxt = CPU_WR;
          w_load      = 1'b1;
          w_grant_cpu = 1'b1;
        end else if (w_cpu_req && !bus.cpu_oe_n) begin
          w_state_nxt = CPU_RD;
          w_load      = 1'b1;
          w_grant_cpu = 1'b1;
        end
      end
      VID, CPU_RD: begin
        if (w_last) w_state_nxt = IDLE;
      end
      CPU_WR: begin
        if (w_last) begin
          if (WR_RECOVER != 0) begin
            w_state_nxt = REC;
            w_load      = 1'b1;
            w_load_val  = cnt_load(WR_RECOVER);
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      REC: begin
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_vid_pend_nxt = w_grant_vid ? 1'b0 : (bus.vid_req ? 1'b1 : r_vid_pend);

  bk_sram_timer #(
    .WIN_TOP (ACCESS_CYC - 1)
  ) u_timer (
    .clk_cpu     (clk_cpu),
    .reset_in    (reset_in),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_last      (w_last),
    .o_we_window (w_we_window)
  );

  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= IDLE;
      r_vid_pend <= 1'b0;
      r_membusy  <= 1'b0;
      r_vid_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vid_pend <= w_vid_pend_nxt;
      r_membusy  <= w_vid_pend_nxt | (w_state_nxt == VID);
      if (bus.vid_req) r_vid_addr <= bus.vid_addr;
    end
  end

  // Access attributes are captured at grant so a dropped request cannot disturb the cycle.
  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      r_acc_addr  <= '0;
      r_acc_lb    <= 1'b1;
      r_acc_ub    <= 1'b1;
      r_acc_wdata <= '0;
    end else if (w_grant_vid) begin
      r_acc_addr  <= {VID_BASE, (bus.vid_req ? bus.vid_addr : r_vid_addr)};
      r_acc_lb    <= 1'b0;
      r_acc_ub    <= 1'b0;
    end else if (w_grant_cpu) begin
      r_acc_addr  <= bus.cpu_addr;
      r_acc_lb    <= bus.cpu_lb;
      r_acc_ub    <= bus.cpu_ub;
      r_acc_wdata <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      r_cpu_rdata <= '0;
      r_vdata     <= '0;
      r_cpu_ack   <= 1'b0;
      r_vid_valid <= 1'b0;
    end else begin
      r_cpu_ack   <= 1'b0;
      r_vid_valid <= 1'b0;
      if (w_last) begin
        case (r_state)
          VID: begin
            r_vdata     <= bus.sram_dq_i;
            r_vid_valid <= 1'b1;
          end
          CPU_RD: begin
            r_cpu_rdata <= bus.sram_dq_i;
            r_cpu_ack   <= 1'b1;
          end
          CPU_WR: r_cpu_ack <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Strobes decode straight from the state register so reset releases them at once.
  assign w_in_acc = (r_state == VID) || (r_state == CPU_RD) || (r_state == CPU_WR);

  assign bus.sram_addr  = r_acc_addr;
  assign bus.sram_dq_o  = r_acc_wdata;
  assign bus.sram_dq_oe = (r_state == CPU_WR);
  assign bus.sram_oe_n  = ~((r_state == VID) || (r_state == CPU_RD));
  assign bus.sram_we_n  = ~((r_state == CPU_WR) && w_we_window);
  assign bus.sram_lb_n  = w_in_acc ? r_acc_lb : 1'b1;
  assign bus.sram_ub_n  = w_in_acc ? r_acc_ub : 1'b1;

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.vdata     = r_vdata;
  assign bus.vid_valid = r_vid_valid;
  assign bus.membusy   = r_membusy;

`ifdef BKMEM_STALL_STATS_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = w_cpu_req & (((r_state == IDLE) & ~w_grant_cpu) | (r_state == VID));

  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bk_sram_arbiter.sv
// Scoreboard bench for bk_sram_arbiter: directed CPU/video traffic against an SRAM model.
module tb_bk_sram_arbiter;

  logic clk_cpu  = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk_cpu = ~clk_cpu;

  bk_sram_arbiter_if bus ();

  bk_sram_arbiter #(
    .ACCESS_CYC (3),
    .VID_BASE   (5'b00001),
    .WR_RECOVER (1)
  ) dut (
    .clk_cpu  (clk_cpu),
    .reset_in (reset_in),
    .bus      (bus)
  );

  logic [15:0] mem [0:262143];

  assign bus.sram_dq_i = bus.sram_oe_n ? 16'hDEAD : mem[bus.sram_addr];

  always @(posedge clk_cpu) begin
    if (!bus.sram_we_n && bus.sram_dq_oe) begin
      if (!bus.sram_lb_n) mem[bus.sram_addr][7:0]  <= bus.sram_dq_o[7:0];
      if (!bus.sram_ub_n) mem[bus.sram_addr][15:8] <= bus.sram_dq_o[15:8];
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    bit          wr;
    logic [17:0] addr;
    logic [15:0] data;
  } cpu_exp_t;

  cpu_exp_t    q_cpu[$];
  logic [15:0] q_vid[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string what);
    n_total++;
    n_bad++;
    $display("FAIL timeout_%s: got no response want one within 40 cycles", what);
  endtask

  // Monitor: every completion pops the oldest expectation of its kind.
  initial begin
    cpu_exp_t e;
    logic [15:0] v;
    forever begin
      @(negedge clk_cpu);
      if (bus.cpu_ack) begin
        if (q_cpu.size() == 0) begin
          check("cpu_ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = q_cpu.pop_front();
          if (e.wr) check("wr_mem_word", {16'h0, mem[e.addr]}, {16'h0, e.data});
          else      check("cpu_rdata", {16'h0, bus.cpu_rdata}, {16'h0, e.data});
        end
      end
      if (bus.vid_valid) begin
        if (q_vid.size() == 0) begin
          check("vid_valid_unexpected", 32'd1, 32'd0);
        end else begin
          v = q_vid.pop_front();
          check("vdata", {16'h0, bus.vdata}, {16'h0, v});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1);
  end

  task automatic run_cpu(input bit wr, input logic [17:0] a, input logic lb, input logic ub,
                         input logic [15:0] wd, input logic [15:0] exp);
    int n, oe_c, we_c, dq_c;
    bit got;
    q_cpu.push_back('{wr, a, exp});
    bus.cpu_addr  = a;
    bus.cpu_lb    = lb;
    bus.cpu_ub    = ub;
    bus.cpu_wdata = wd;
    if (wr) bus.cpu_we_n = 1'b0;
    else    bus.cpu_oe_n = 1'b0;
    n = 0; oe_c = 0; we_c = 0; dq_c = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk_cpu); #1; n++;
      @(negedge clk_cpu);
      if (!bus.sram_oe_n) oe_c++;
      if (!bus.sram_we_n) begin
        we_c++;
        check("wr_dq_o", {16'h0, bus.sram_dq_o}, {16'h0, wd});
      end
      if (bus.sram_dq_oe) dq_c++;
      if (bus.cpu_ack) begin
        got = 1'b1;
        if (wr) check("rec_dq_oe", {31'h0, bus.sram_dq_oe}, 32'd0);
      end
    end
    if (!got) timeout_fail("cpu_ack");
    check(wr ? "wr_ack_latency" : "rd_ack_latency", n, 4);
    if (wr) begin
      check("wr_we_low_cycles", we_c, 1);
      check("wr_dq_oe_cycles", dq_c, 3);
    end else begin
      check("rd_oe_low_cycles", oe_c, 3);
      check("rd_we_low_cycles", we_c, 0);
    end
    @(posedge clk_cpu); #1;
    bus.cpu_oe_n = 1'b1;
    bus.cpu_we_n = 1'b1;
  endtask

  initial begin
    int n, vv_n, ack_n, oe_c, we_c, start_n, ack_cnt;
    logic [17:0] addr1, addr5;
    logic mb1, mb3, mb4;

    bus.cpu_oe_n  = 1'b1;
    bus.cpu_we_n  = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_lb    = 1'b0;
    bus.cpu_ub    = 1'b0;
    bus.cpu_wdata = '0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    mem[18'h00100] <= 16'hA5C3;
    mem[18'h00140] <= 16'h1357;
    mem[18'h00180] <= 16'h0180;
    mem[18'h00200] <= 16'hFFFF;
    mem[18'h00300] <= 16'h0000;
    mem[18'h02005] <= 16'hBEEF;
    mem[18'h02007] <= 16'h7777;
    mem[18'h02123] <= 16'h5A5A;

    repeat (2) @(posedge clk_cpu);
    #1;
    check("rst_strobes", {24'h0, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n,
                          bus.sram_dq_oe, bus.cpu_ack, bus.vid_valid, bus.membusy}, 32'h000000F0);
    check("rst_cpu_rdata", {16'h0, bus.cpu_rdata}, 32'h0);
    check("rst_vdata", {16'h0, bus.vdata}, 32'h0);
    check("rst_stall_cnt", {16'h0, bus.stall_cnt}, 32'h0);
    reset_in = 1'b0;
    @(posedge clk_cpu); #1;

    // Plain read and byte write.
    run_cpu(1'b0, 18'h00100, 1'b0, 1'b0, 16'h0000, 16'hA5C3);
    run_cpu(1'b1, 18'h00200, 1'b0, 1'b1, 16'h1234, 16'hFF34);

    // Contention: video and CPU read requested in the same cycle.
    q_vid.push_back(16'hBEEF);
    q_cpu.push_back('{1'b0, 18'h00140, 16'h1357});
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h0005;
    bus.cpu_addr = 18'h00140;
    bus.cpu_oe_n = 1'b0;
    n = 0; vv_n = 0; ack_n = 0; oe_c = 0;
    addr1 = '0; addr5 = '0; mb1 = 1'b0; mb3 = 1'b0; mb4 = 1'b1;
    while (ack_n == 0 && n < 40) begin
      @(posedge clk_cpu); #1; n++;
      if (n == 1) bus.vid_req = 1'b0;
      @(negedge clk_cpu);
      if (!bus.sram_oe_n) oe_c++;
      if (n == 1) begin addr1 = bus.sram_addr; mb1 = bus.membusy; end
      if (n == 3) mb3 = bus.membusy;
      if (n == 4) mb4 = bus.membusy;
      if (n == 5) addr5 = bus.sram_addr;
      if (bus.vid_valid) vv_n = n;
      if (bus.cpu_ack) ack_n = n;
    end
    if (ack_n == 0) timeout_fail("contention_ack");
    check("cont_vid_addr_first", {14'h0, addr1}, 32'h02005);
    check("cont_membusy_c1", {31'h0, mb1}, 32'd1);
    check("cont_membusy_c3", {31'h0, mb3}, 32'd1);
    check("cont_membusy_after_vid", {31'h0, mb4}, 32'd0);
    check("cont_vid_valid_cycle", vv_n, 4);
    check("cont_cpu_addr", {14'h0, addr5}, 32'h00140);
    check("cont_cpu_ack_cycle", ack_n, 8);
    check("cont_oe_low_cycles", oe_c, 6);
    @(posedge clk_cpu); #1;
    bus.cpu_oe_n = 1'b1;

    // Queued video: strobe during the write lands after the recovery cycle.
    q_cpu.push_back('{1'b1, 18'h00300, 16'hC0DE});
    q_vid.push_back(16'h5A5A);
    bus.cpu_addr  = 18'h00300;
    bus.cpu_lb    = 1'b0;
    bus.cpu_ub    = 1'b0;
    bus.cpu_wdata = 16'hC0DE;
    bus.cpu_we_n  = 1'b0;
    n = 0; vv_n = 0; ack_n = 0; we_c = 0; start_n = 0; mb3 = 1'b0; addr1 = '0;
    while (vv_n == 0 && n < 40) begin
      @(posedge clk_cpu); #1; n++;
      if (n == 2) begin bus.vid_req = 1'b1; bus.vid_addr = 13'h0123; end
      if (n == 3) bus.vid_req = 1'b0;
      if (n == 5) bus.cpu_we_n = 1'b1;
      @(negedge clk_cpu);
      if (!bus.sram_we_n) we_c++;
      if (n == 3) mb3 = bus.membusy;
      if (!bus.sram_oe_n && start_n == 0) begin start_n = n; addr1 = bus.sram_addr; end
      if (bus.cpu_ack) ack_n = n;
      if (bus.vid_valid) vv_n = n;
    end
    if (vv_n == 0) timeout_fail("queued_vid_valid");
    check("q_wr_ack_cycle", ack_n, 4);
    check("q_we_low_cycles", we_c, 1);
    check("q_membusy_pending", {31'h0, mb3}, 32'd1);
    check("q_vid_start_cycle", start_n, 6);
    check("q_vid_addr", {14'h0, addr1}, 32'h02123);
    check("q_vid_valid_cycle", vv_n, 9);
    check("q_wr_word_kept", {16'h0, mem[18'h00300]}, 32'h0000C0DE);
    @(posedge clk_cpu); #1;

    // Reset in the middle of a read.
    bus.cpu_addr = 18'h00100;
    bus.cpu_oe_n = 1'b0;
    @(posedge clk_cpu); #1;
    @(posedge clk_cpu); #3;
    check("rst_mid_oe_active", {31'h0, bus.sram_oe_n}, 32'd0);
    reset_in = 1'b1;
    #1;
    check("rst_mid_oe_released", {31'h0, bus.sram_oe_n}, 32'd1);
    bus.cpu_oe_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_cpu); #1;
      if (i == 2) reset_in = 1'b0;
      @(negedge clk_cpu);
      if (bus.cpu_ack) ack_cnt++;
    end
    check("rst_no_ack", ack_cnt, 0);
    check("rst_rdata_cleared", {16'h0, bus.cpu_rdata}, 32'h0);
    check("rst_idle_strobes", {28'h0, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.membusy},
          32'hC);
    @(posedge clk_cpu); #1;
    run_cpu(1'b0, 18'h00100, 1'b0, 1'b0, 16'h0000, 16'hA5C3);

    // CPU read held off by one video fetch.
    q_vid.push_back(16'h7777);
    q_cpu.push_back('{1'b0, 18'h00180, 16'h0180});
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h0007;
    n = 0; ack_n = 0;
    while (ack_n == 0 && n < 40) begin
      @(posedge clk_cpu); #1; n++;
      if (n == 1) begin
        bus.vid_req  = 1'b0;
        bus.cpu_addr = 18'h00180;
        bus.cpu_oe_n = 1'b0;
      end
      @(negedge clk_cpu);
      if (bus.cpu_ack) ack_n = n;
    end
    if (ack_n == 0) timeout_fail("stall_ack");
    check("stall_ack_cycle", ack_n, 8);
    @(posedge clk_cpu); #1;
    bus.cpu_oe_n = 1'b1;
`ifdef BKMEM_STALL_STATS_EN
    check("stall_cnt", {16'h0, bus.stall_cnt}, 32'd3);
`else
    check("stall_cnt_tied", {16'h0, bus.stall_cnt}, 32'd0);
`endif

    repeat (2) @(posedge clk_cpu);
    #1;
    check("q_cpu_drained", q_cpu.size(), 0);
    check("q_vid_drained", q_vid.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
